// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: control registers in, pin drive and period pulse out
interface pwm_peripheral_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [15:0] out;
  logic period_start;
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins forced low/high or driven by one shared glitch-free PWM
module pwm_peripheral #(
  parameter int CLK_DIV = 3000
) (
  input logic clk,
  input logic rst,
  pwm_peripheral_if.slave bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [PW-1:0] presc;
  logic [7:0] pwm_cnt, duty_sh, eff_duty;
  logic [15:0] en_out, en_pwm;
  logic tick, ps, pwm_level;
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign tick = presc == PW'(CLK_DIV - 1);
  assign ps = (presc == '0) && (pwm_cnt == 8'd0);
  // duty is latched at period start so a mid-period write cannot cut a pulse short
  assign eff_duty = ps ? bus.pwm_duty_cycle : duty_sh;
  assign pwm_level = (eff_duty == 8'hFF) || (pwm_cnt < eff_duty);
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      pwm_cnt <= 8'd0;
      duty_sh <= 8'd0;
      bus.out <= 16'h0000;
      bus.period_start <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (ps) duty_sh <= bus.pwm_duty_cycle;
      bus.out <= en_out & (~en_pwm | {16{pwm_level}});
      bus.period_start <= ps;
    end
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: per-period scoreboard for two instances (CLK_DIV=4 and CLK_DIV=1)
module tb_pwm_peripheral;
  typedef struct {
    int len;
    int hi0;
    int hi4;
    int first0;
    logic [15:0] mask;
    logic [15:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic sel = 1'b0;
  logic [15:0] eo = 16'hFFFF;
  logic [15:0] ep = 16'hFFFF;
  logic [7:0] duty = 8'hFF;
  logic ps_sel;
  logic [15:0] out_sel;
  int checks = 0;
  int errors = 0;
  int P = 1024;
  exp_t q[$];
  pwm_peripheral_if ia();
  pwm_peripheral_if ib();
  assign ia.en_reg_out_7_0 = eo[7:0];
  assign ia.en_reg_out_15_8 = eo[15:8];
  assign ia.en_reg_pwm_7_0 = ep[7:0];
  assign ia.en_reg_pwm_15_8 = ep[15:8];
  assign ia.pwm_duty_cycle = duty;
  assign ib.en_reg_out_7_0 = eo[7:0];
  assign ib.en_reg_out_15_8 = eo[15:8];
  assign ib.en_reg_pwm_7_0 = ep[7:0];
  assign ib.en_reg_pwm_15_8 = ep[15:8];
  assign ib.pwm_duty_cycle = duty;
  assign ps_sel = sel ? ib.period_start : ia.period_start;
  assign out_sel = sel ? ib.out : ia.out;
  pwm_peripheral #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  pwm_peripheral #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
  always #5 clk = ~clk;
  function automatic exp_t mk(int len, int hi0, int hi4, int first0, logic [15:0] mask, logic [15:0] val);
    exp_t e;
    e.len = len;
    e.hi0 = hi0;
    e.hi4 = hi4;
    e.first0 = first0;
    e.mask = mask;
    e.val = val;
    return e;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps_sel && n < 2 * P + 8);
    if (!ps_sel) n = -1;
  endtask
  // run through one period (pulse to last cycle), then load the next period's config
  task automatic per(input int mid_j, input logic [7:0] mid_d, input logic [15:0] eo_n,
                     input logic [15:0] ep_n, input logic [7:0] d_n, input exp_t e);
    int n;
    wait_pulse(n);
    chk("period_start_spacing", n, 1);
    if (mid_j > 0) begin
      repeat (mid_j) @(negedge clk);
      duty = mid_d;
      repeat (P - 1 - mid_j) @(negedge clk);
    end else begin
      repeat (P - 1) @(negedge clk);
    end
    eo = eo_n;
    ep = ep_n;
    duty = d_n;
    q.push_back(e);
  endtask
  // monitor: a window spans period_start pulse to the next pulse
  initial begin
    exp_t cur;
    logic open, sel_d;
    int wlen, h0, h4, f0, viol;
    open = 1'b0;
    sel_d = 1'b0;
    cur = mk(0, 0, 0, 0, 16'h0, 16'h0);
    wlen = 0; h0 = 0; h4 = 0; f0 = 0; viol = 0;
    forever begin
      @(negedge clk);
      if (sel != sel_d) open = 1'b0;
      sel_d = sel;
      if (ps_sel) begin
        if (open) begin
          chk("window_len", wlen, cur.len);
          chk("out0_high_cycles", h0, cur.hi0);
          chk("out4_high_cycles", h4, cur.hi4);
          chk("out0_first_cycle", f0, cur.first0);
          chk("static_bits_bad_cycles", viol, 0);
        end
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: period_start seen, no expected record");
          open = 1'b0;
        end else begin
          cur = q.pop_front();
          open = 1'b1;
          wlen = 0; h0 = 0; h4 = 0; viol = 0;
          f0 = int'(out_sel[0]);
        end
      end
      if (open) begin
        wlen++;
        h0 += int'(out_sel[0]);
        h4 += int'(out_sel[4]);
        if ((out_sel & cur.mask) != cur.val) viol++;
      end
    end
  end
  initial begin
    int n;
    exp_t e_half, e_off, e_on, e_one, e_gate;
    e_half = mk(1024, 512, 1024, 1, 16'hFFFE, 16'hFFFE);
    e_off = mk(1024, 0, 1024, 0, 16'hFFFE, 16'hFFFE);
    e_on = mk(1024, 1024, 1024, 1, 16'hFFFE, 16'hFFFE);
    e_one = mk(1024, 4, 1024, 1, 16'hFFFE, 16'hFFFE);
    e_gate = mk(1024, 0, 512, 0, 16'hFFCF, 16'h00C0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_out", int'(out_sel), 0);
      chk("reset_period_start", int'(ps_sel), 0);
    end
    q.push_back(mk(1024, 1024, 1024, 1, 16'hFFFF, 16'hFFFF));
    rst_a = 1'b0;
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h80, e_half);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h00, e_off);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h00, e_off);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h00, e_off);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'hFF, e_on);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'hFF, e_on);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'hFF, e_on);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h01, e_one);
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h40, mk(1024, 256, 1024, 1, 16'hFFFE, 16'hFFFE));
    per(128, 8'hC0, 16'hFFFF, 16'h0001, 8'hC0, mk(1024, 768, 1024, 1, 16'hFFFE, 16'hFFFE));
    per(0, 8'h00, 16'h00F0, 16'h0030, 8'h80, e_gate);
    per(0, 8'h00, 16'h00F0, 16'h0030, 8'h80, mk(1024, 0, 412, 0, 16'hFFCF, 16'h00C0));
    wait_pulse(n);
    chk("period_start_spacing", n, 1);
    repeat (100) @(negedge clk);
    chk("en4_before_toggle", int'(out_sel[4]), 1);
    eo[4] = 1'b0;
    @(negedge clk);
    chk("en4_off_next_cycle", int'(out_sel[4]), 0);
    repeat (99) @(negedge clk);
    eo[4] = 1'b1;
    @(negedge clk);
    chk("en4_on_next_cycle", int'(out_sel[4]), 1);
    repeat (P - 1 - 201) @(negedge clk);
    q.push_back(e_gate);
    wait_pulse(n);
    chk("period_start_spacing", n, 1);
    rst_a = 1'b1;
    sel = 1'b1;
    P = 256;
    eo = 16'hFFFF;
    ep = 16'h0001;
    duty = 8'h03;
    repeat (2) @(negedge clk);
    q.push_back(mk(256, 3, 256, 1, 16'hFFFE, 16'hFFFE));
    rst_b = 1'b0;
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h03, mk(145, 3, 144, 1, 16'h0000, 16'h0000));
    wait_pulse(n);
    chk("period_start_spacing", n, 1);
    repeat (8'h8F) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("midreset_out", int'(out_sel), 0);
    chk("midreset_period_start", int'(ps_sel), 0);
    q.push_back(mk(256, 3, 256, 1, 16'hFFFE, 16'hFFFE));
    rst_b = 1'b0;
    per(0, 8'h00, 16'hFFFF, 16'h0001, 8'h03, mk(256, 3, 256, 1, 16'hFFFE, 16'hFFFE));
    wait_pulse(n);
    chk("period_start_spacing", n, 1);
    @(negedge clk);
    chk("scoreboard_leftover", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
